// File: rtl/dlx_pkg.sv
// Shared DLX multicycle definitions: phase encoding (matches the controller state)
// and the error codes reported by the phase checker.
package dlx_pkg;

    typedef enum logic [2:0] {
        P_IF  = 3'd0,
        P_ID  = 3'd1,
        P_EX  = 3'd2,
        P_MEM = 3'd3,
        P_WB  = 3'd4
    } phase_t;

    typedef enum logic {
        WAIT_IF = 1'b0,
        TRACK   = 1'b1
    } chk_state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_ORDER  = 2'b10;

    function automatic phase_t next_phase(input phase_t p);
        return (p == P_WB) ? P_IF : phase_t'(p + 3'd1);
    endfunction

endpackage

// File: rtl/phase_enc.sv
// One-hot phase-strobe encoder; strobes[0]=IF .. strobes[4]=WB.
module phase_enc
    import dlx_pkg::*;
(
    input  logic [4:0] strobes,
    output phase_t     phase,
    output logic       is_onehot
);

    always_comb begin
        is_onehot = 1'b1;
        phase     = P_IF;
        case (strobes)
            5'b00001: phase = P_IF;
            5'b00010: phase = P_ID;
            5'b00100: phase = P_EX;
            5'b01000: phase = P_MEM;
            5'b10000: phase = P_WB;
            default:  is_onehot = 1'b0;
        endcase
    end

endmodule

// File: rtl/phase_checker.sv
// Phase-strobe checker: encodes the active phase, verifies one-hot and IF..WB order,
// counts retired instructions and cycles, and keeps sticky error state.
module phase_checker
    import dlx_pkg::*;
#(
    parameter int CNT_W             = 32,
    parameter bit RETIRE_NEEDS_FULL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IF,
    input  logic             ID,
    input  logic             EX,
    input  logic             MEM,
    input  logic             WB,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             err_onehot,
    output logic             err_order,
    output logic             err_sticky,
    output logic [1:0]       err_code
);

    phase_t     samp_phase;
    logic       samp_onehot;
    chk_state_t state, state_n;
    phase_t     expected, expected_n;
    logic       clean, clean_n;
    logic [2:0] phase_n;
    logic       retire_n, err_onehot_n, err_order_n, err_sticky_n;
    logic [1:0] err_code_n, new_code;

    phase_enc u_enc (
        .strobes   ({WB, MEM, EX, ID, IF}),
        .phase     (samp_phase),
        .is_onehot (samp_onehot)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= WAIT_IF;
            expected    <= P_IF;
            clean       <= 1'b0;
            phase       <= 3'd0;
            phase_valid <= 1'b0;
            retire      <= 1'b0;
            instr_cnt   <= '0;
            cycle_cnt   <= '0;
            err_onehot  <= 1'b0;
            err_order   <= 1'b0;
            err_sticky  <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state       <= state_n;
            expected    <= expected_n;
            clean       <= clean_n;
            phase       <= phase_n;
            phase_valid <= samp_onehot;
            retire      <= retire_n;
            instr_cnt   <= retire_n ? instr_cnt + CNT_W'(1) : instr_cnt;
            cycle_cnt   <= cycle_cnt + CNT_W'(1);
            err_onehot  <= err_onehot_n;
            err_order   <= err_order_n;
            err_sticky  <= err_sticky_n;
            err_code    <= err_code_n;
        end
    end

    always_comb begin
        state_n      = state;
        expected_n   = expected;
        clean_n      = clean;
        phase_n      = phase;
        retire_n     = 1'b0;
        err_onehot_n = 1'b0;
        err_order_n  = 1'b0;
        new_code     = ERR_NONE;

        if (!samp_onehot) begin
            err_onehot_n = 1'b1;
            new_code     = ERR_ONEHOT;
            clean_n      = 1'b0;
            state_n      = WAIT_IF;
        end else begin
            phase_n = samp_phase;
            if (state == WAIT_IF) begin
                if (samp_phase == P_IF) begin
                    state_n    = TRACK;
                    expected_n = P_ID;
                    clean_n    = 1'b1;
                end else begin
                    clean_n = 1'b0;
                end
            end else if (samp_phase == expected) begin
                expected_n = next_phase(expected);
                if (samp_phase == P_IF) begin
                    clean_n = 1'b1;
                end
                // Every in-order WB closes the current instruction's clean window.
                if (samp_phase == P_WB) begin
                    retire_n = !RETIRE_NEEDS_FULL || clean;
                    clean_n  = 1'b0;
                end
            end else begin
                err_order_n = 1'b1;
                new_code    = ERR_ORDER;
                if (samp_phase == P_IF) begin
                    expected_n = P_ID;
                    clean_n    = 1'b1;
                end else begin
                    state_n = WAIT_IF;
                    clean_n = 1'b0;
                end
            end
        end

        // A fresh error beats a simultaneous clear; otherwise only the first error is kept.
        err_sticky_n = err_sticky && !clr_err;
        err_code_n   = clr_err ? ERR_NONE : err_code;
        if (new_code != ERR_NONE) begin
            err_sticky_n = 1'b1;
            if (clr_err || err_code == ERR_NONE) begin
                err_code_n = new_code;
            end
        end
    end

endmodule

// File: tb/tb_phase_checker.sv
// Self-checking bench for phase_checker: directed scenarios with literal expectations,
// then randomized strobe traffic compared every cycle against a behavioural model.
module tb_phase_checker;
    localparam int CNT_W = 4;
    localparam int MOD   = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             s_if = 1'b0, s_id = 1'b0, s_ex = 1'b0, s_mem = 1'b0, s_wb = 1'b0;
    logic             clr_err = 1'b0;
    logic [2:0]       phase;
    logic             phase_valid, retire, err_onehot, err_order, err_sticky;
    logic [CNT_W-1:0] instr_cnt, cycle_cnt;
    logic [1:0]       err_code;

    int checks = 0;
    int errors = 0;

    phase_checker #(.CNT_W(CNT_W), .RETIRE_NEEDS_FULL(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .IF          (s_if),
        .ID          (s_id),
        .EX          (s_ex),
        .MEM         (s_mem),
        .WB          (s_wb),
        .clr_err     (clr_err),
        .phase       (phase),
        .phase_valid (phase_valid),
        .retire      (retire),
        .instr_cnt   (instr_cnt),
        .cycle_cnt   (cycle_cnt),
        .err_onehot  (err_onehot),
        .err_order   (err_order),
        .err_sticky  (err_sticky),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    // Behavioural model: integer phase indices, in-sync flag and counters modulo 2^CNT_W.
    int m_phase = 0, m_valid = 0, m_retire = 0, m_instr = 0, m_cycle = 0;
    int m_eoh = 0, m_eord = 0, m_sticky = 0, m_code = 0;
    int m_expect = 0;
    bit m_sync = 0, m_clean = 0;

    always @(posedge clk) begin
        logic [4:0] s;
        int n, idx, newcode;
        s = {s_wb, s_mem, s_ex, s_id, s_if};
        if (reset) begin
            m_phase = 0; m_valid = 0; m_retire = 0; m_instr = 0; m_cycle = 0;
            m_eoh = 0; m_eord = 0; m_sticky = 0; m_code = 0;
            m_expect = 0; m_sync = 0; m_clean = 0;
        end else begin
            n = $countones(s);
            idx = 0;
            for (int i = 0; i < 5; i++) if (s[i]) idx = i;
            m_cycle = (m_cycle + 1) % MOD;
            m_retire = 0; m_eoh = 0; m_eord = 0; newcode = 0;
            if (n != 1) begin
                m_valid = 0; m_eoh = 1; newcode = 1; m_sync = 0; m_clean = 0;
            end else begin
                m_valid = 1;
                m_phase = idx;
                if (!m_sync) begin
                    if (idx == 0) begin m_sync = 1; m_expect = 1; m_clean = 1; end
                    else m_clean = 0;
                end else if (idx == m_expect) begin
                    if (idx == 0) m_clean = 1;
                    if (idx == 4) begin
                        if (m_clean) begin m_retire = 1; m_instr = (m_instr + 1) % MOD; end
                        m_clean = 0;
                    end
                    m_expect = (m_expect + 1) % 5;
                end else begin
                    m_eord = 1; newcode = 2;
                    if (idx == 0) begin m_expect = 1; m_clean = 1; end
                    else begin m_sync = 0; m_clean = 0; end
                end
            end
            if (newcode != 0) begin
                if (m_code == 0 || clr_err) m_code = newcode;
                m_sticky = 1;
            end else if (clr_err) begin
                m_code = 0; m_sticky = 0;
            end
        end
    end

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, required, $time);
        end
    endtask

    bit run_cmp = 0;
    always @(negedge clk) begin
        if (run_cmp) begin
            check("phase",       int'(phase),       m_phase);
            check("phase_valid", int'(phase_valid), m_valid);
            check("retire",      int'(retire),      m_retire);
            check("instr_cnt",   int'(instr_cnt),   m_instr);
            check("cycle_cnt",   int'(cycle_cnt),   m_cycle);
            check("err_onehot",  int'(err_onehot),  m_eoh);
            check("err_order",   int'(err_order),   m_eord);
            check("err_sticky",  int'(err_sticky),  m_sticky);
            check("err_code",    int'(err_code),    m_code);
        end
    end

    // Drive one sample (bit0=IF .. bit4=WB); returns once the DUT has registered it.
    task automatic applyStimulus(input logic [4:0] s, input logic clr, input logic rst);
        {s_wb, s_mem, s_ex, s_id, s_if} = s;
        clr_err = clr;
        reset   = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic loop_instr(input int count);
        for (int k = 0; k < count; k++)
            for (int p = 0; p < 5; p++) applyStimulus(5'(1 << p), 1'b0, 1'b0);
    endtask

    localparam logic [4:0] S_IF = 5'b00001, S_ID = 5'b00010, S_EX = 5'b00100,
                           S_MEM = 5'b01000, S_WB = 5'b10000;

    initial begin
        int gen_ptr;
        int r;
        logic [4:0] s;
        applyStimulus(5'b0, 1'b0, 1'b1);
        applyStimulus(5'b0, 1'b0, 1'b1);
        run_cmp = 1;
        check("rst_phase", int'(phase), 0);
        check("rst_valid", int'(phase_valid), 0);
        check("rst_cycle", int'(cycle_cnt), 0);
        check("rst_code",  int'(err_code), 0);

        loop_instr(3);
        check("loop_instr", int'(instr_cnt), 3);
        check("loop_cycle", int'(cycle_cnt), 15);
        check("loop_retire", int'(retire), 1);
        check("loop_phase", int'(phase), 4);
        check("loop_sticky", int'(err_sticky), 0);

        applyStimulus(S_IF, 0, 0); applyStimulus(S_ID, 0, 0); applyStimulus(S_EX, 0, 0);
        applyStimulus(5'b0, 0, 0);
        check("zh_pulse", int'(err_onehot), 1);
        check("zh_code", int'(err_code), 1);
        check("zh_hold", int'(phase), 2);
        applyStimulus(S_MEM, 0, 0); applyStimulus(S_WB, 0, 0);
        check("zh_noretire", int'(retire), 0);
        loop_instr(1);
        check("resync_retire", int'(retire), 1);
        check("resync_instr", int'(instr_cnt), 4);

        applyStimulus(S_IF, 1'b1, 0);
        check("clr_code", int'(err_code), 0);
        check("clr_sticky", int'(err_sticky), 0);
        applyStimulus(S_ID, 0, 0); applyStimulus(S_MEM, 0, 0);
        check("ord_pulse", int'(err_order), 1);
        check("ord_code", int'(err_code), 2);
        applyStimulus(S_WB, 0, 0);
        check("ord_noretire", int'(retire), 0);
        loop_instr(1);
        check("ord_resume", int'(retire), 1);

        applyStimulus(5'b0, 1'b1, 0);
        check("clr_vs_err", int'(err_code), 1);
        applyStimulus(S_IF | S_WB, 1'b1, 0);
        applyStimulus(S_IF | S_WB, 1'b1, 0);
        check("mh_valid", int'(phase_valid), 0);
        check("mh_hold", int'(phase), 4);
        applyStimulus(S_IF, 1'b0, 0);
        applyStimulus(S_EX, 1'b1, 0);
        check("clr_new_sticky", int'(err_sticky), 1);
        check("clr_new_code", int'(err_code), 2);
        applyStimulus(S_IF, 1'b1, 0);
        check("clr_alone", int'(err_code), 0);

        applyStimulus(S_ID, 0, 0); applyStimulus(S_EX, 0, 0); applyStimulus(S_MEM, 0, 0);
        applyStimulus(S_MEM, 0, 1);
        check("midrst_cycle", int'(cycle_cnt), 0);
        check("midrst_instr", int'(instr_cnt), 0);
        check("midrst_phase", int'(phase), 0);
        applyStimulus(S_WB, 0, 0);
        check("midrst_noretire", int'(retire), 0);
        check("midrst_noerr", int'(err_sticky), 0);
        loop_instr(17);
        check("wrap_instr", int'(instr_cnt), 1);

        gen_ptr = 0;
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            if (r < 85) begin
                s = 5'(1 << gen_ptr);
                gen_ptr = (gen_ptr + 1) % 5;
            end else if (r < 91) begin
                s = 5'(1 << $urandom_range(0, 4));
            end else if (r < 97) begin
                s = 5'($urandom_range(0, 31));
            end else begin
                s = 5'b0;
            end
            applyStimulus(s, ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        run_cmp = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
